measure_slow_clk_period: RTL

Receive-side counterpart of the on-board slow clock generator. Takes an asynchronous low-frequency square wave (nominally the 1.49 Hz divided clock, looped back or driven from another board), synchronizes it into the 100 MHz domain and measures each full period and high time in clk_100mhz cycles. Publishes each result with a one-cycle valid strobe and flags loss of signal with a timeout. Sits beside the clock generator at top level so the self-test can check the divider output against its nominal 2^26-cycle period.

---
 rtl/measure_slow_clk_period.sv | 133 +++++++++++++
 1 files changed

// File: rtl/measure_slow_clk_period.sv
// Measures period and high time of an asynchronous slow clock in clk_100mhz cycles.
// Each rising edge closes one interval; loss of edges is flagged by a timeout level.
module measure_slow_clk_period #(
  parameter int COUNT_WIDTH    = 28,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 134217728
) (
  input  logic                   clk_100mhz,
  input  logic                   rst,
  input  logic                   clk_in,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [COUNT_WIDTH-1:0] high_time,
  output logic                   period_valid,
  output logic                   timeout
);

  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_VAL = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] ONE         = COUNT_WIDTH'(1);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    MEASURING  = 2'd1,
    TIMED_OUT  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   prev;
  logic                   rise;

  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] hcnt;
  logic                   cnt_sat;

  logic capture;
  logic set_timeout;
  logic clr_timeout;
  logic hold_cnt;

  // clk_in enters at bit 0 and shifts toward the top stage.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync    = sync_q[SYNC_STAGES-1];
  assign rise    = sync & ~prev;
  assign cnt_sat = (cnt == TIMEOUT_VAL);

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state <= WAIT_FIRST;
    end else begin
      state <= state_next;
    end
  end

  // A rise in the same cycle the counter saturates takes priority over timeout.
  always_comb begin
    state_next = state;
    case (state)
      WAIT_FIRST: if (rise)             state_next = MEASURING;
      MEASURING:  if (!rise && cnt_sat) state_next = TIMED_OUT;
      TIMED_OUT:  if (rise)             state_next = MEASURING;
      default:                          state_next = WAIT_FIRST;
    endcase
  end

  always_comb begin
    capture     = 1'b0;
    set_timeout = 1'b0;
    clr_timeout = 1'b0;
    hold_cnt    = 1'b0;
    case (state)
      MEASURING: begin
        capture     = rise;
        set_timeout = !rise && cnt_sat;
      end
      TIMED_OUT: begin
        clr_timeout = rise;
        hold_cnt    = !rise;
      end
      default: ;
    endcase
  end

  // Both counters include the rise cycle itself, so period = t1 - t0 exactly.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= ONE;
      hcnt <= ONE;
    end else if (!hold_cnt) begin
      if (!cnt_sat) begin
        cnt <= cnt + ONE;
      end
      if (sync && (hcnt != TIMEOUT_VAL)) begin
        hcnt <= hcnt + ONE;
      end
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= capture;
      if (capture) begin
        period    <= cnt;
        high_time <= hcnt;
      end
      if (set_timeout) begin
        timeout <= 1'b1;
      end else if (clr_timeout) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule
